// File: rtl/inst_cache_pkg.sv
// rtl/inst_cache_pkg.sv - shared types, constants and word-select helper for inst_cache
package inst_cache_pkg;

  localparam int LINE_BEATS  = 8;
  localparam int LINE_ADDR_W = 58;

  localparam logic [12:0] TAG_READ = 13'b1_1100_0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_FILL,
    RESPOND
  } state_t;

  typedef logic [LINE_BEATS-1:0][63:0] line_t;

  // word[3:1] picks the beat, word[0] picks the upper or lower half of it
  function automatic logic [31:0] select_word(input line_t line, input logic [3:0] word);
    logic [63:0] beat;
    beat = line[word[3:1]];
    return word[0] ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/inst_cache_if.sv
// rtl/inst_cache_if.sv - fetch-side request/response and system-bus signals of inst_cache
interface inst_cache_if
  import inst_cache_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
) ();

  logic                      ic_req;
  logic [LINE_ADDR_W-1:0]    ic_line_addr;
  logic [3:0]                ic_word_select;
  logic                      ic_ack;
  logic [63:0]               ic_data_out;

  logic                      bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      bus_respack;

  modport slave (
    input  ic_req, ic_line_addr, ic_word_select,
    output ic_ack, ic_data_out,
    output bus_reqcyc, bus_req, bus_reqtag,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    output bus_respack
  );

  modport master (
    output ic_req, ic_line_addr, ic_word_select,
    input  ic_ack, ic_data_out,
    input  bus_reqcyc, bus_req, bus_reqtag,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    input  bus_respack
  );

endinterface

// File: rtl/inst_cache_array.sv
// rtl/inst_cache_array.sv - valid/tag/line storage with registered read and full-line write
module inst_cache_array
  import inst_cache_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int TAG_W = 52
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_rd_en,
  input  logic [$clog2(SETS)-1:0] i_rd_idx,
  output logic                    o_rd_valid,
  output logic [TAG_W-1:0]        o_rd_tag,
  output line_t                   o_rd_line,
  input  logic                    i_wr_en,
  input  logic [$clog2(SETS)-1:0] i_wr_idx,
  input  logic [TAG_W-1:0]        i_wr_tag,
  input  line_t                   i_wr_line
);

  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag  [SETS];
  line_t            r_data [SETS];
  logic             r_rd_valid;
  logic [TAG_W-1:0] r_rd_tag;
  line_t            r_rd_line;

  // Only the valid bits carry reset; tag and data are don't-care until valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (i_wr_en) r_valid[i_wr_idx] <= 1'b1;
      if (i_rd_en) r_rd_valid <= r_valid[i_rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_line;
    end
    if (i_rd_en) begin
      r_rd_tag  <= r_tag[i_rd_idx];
      r_rd_line <= r_data[i_rd_idx];
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_tag   = r_rd_tag;
  assign o_rd_line  = r_rd_line;

endmodule

// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped instruction cache between fetch and the system bus
// INST_CACHE_CRITICAL_WORD_EN: acknowledge as soon as the requested beat arrives during a fill.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int SETS           = 64
) (
  input  logic        clk,
  input  logic        reset,
  inst_cache_if.slave ic_bus
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = LINE_ADDR_W - IDX_W;
  localparam int BEAT_W = $clog2(LINE_BEATS);

  state_t                    r_state;
  logic [LINE_ADDR_W-1:0]    r_line_addr;
  logic [3:0]                r_word;
  logic [BEAT_W-1:0]         r_beat;
  line_t                     r_line_buf;
  logic                      r_ack;
  logic [63:0]               r_data;
  logic                      r_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] r_req;
  logic [BUS_TAG_WIDTH-1:0]  r_reqtag;

  logic             w_rd_en;
  logic             w_rd_valid;
  logic [TAG_W-1:0] w_rd_tag;
  line_t            w_rd_line;
  line_t            w_fill_line;
  logic             w_hit;
  logic             w_beat_acc;
  logic             w_last_beat;
  logic             w_crit_beat;
  logic             w_unused_resptag;

  assign w_rd_en     = (r_state == IDLE) && ic_bus.ic_req;
  assign w_hit       = w_rd_valid && (w_rd_tag == r_line_addr[LINE_ADDR_W-1:IDX_W]);
  assign w_beat_acc  = (r_state == MISS_FILL) && ic_bus.bus_respcyc;
  assign w_last_beat = w_beat_acc && (r_beat == BEAT_W'(LINE_BEATS - 1));

`ifdef INST_CACHE_CRITICAL_WORD_EN
  assign w_crit_beat = w_beat_acc && (r_beat == r_word[3:1]);
`else
  assign w_crit_beat = w_last_beat;
`endif

  // Line as it will look once the beat on the bus this cycle is merged in.
  always_comb begin
    w_fill_line         = r_line_buf;
    w_fill_line[r_beat] = ic_bus.bus_resp;
  end

  inst_cache_array #(
    .SETS  (SETS),
    .TAG_W (TAG_W)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .i_rd_en    (w_rd_en),
    .i_rd_idx   (ic_bus.ic_line_addr[IDX_W-1:0]),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_line  (w_rd_line),
    .i_wr_en    (w_last_beat),
    .i_wr_idx   (r_line_addr[IDX_W-1:0]),
    .i_wr_tag   (r_line_addr[LINE_ADDR_W-1:IDX_W]),
    .i_wr_line  (w_fill_line)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_line_addr <= '0;
      r_word      <= '0;
      r_beat      <= '0;
      r_line_buf  <= '0;
      r_ack       <= 1'b0;
      r_data      <= '0;
      r_reqcyc    <= 1'b0;
      r_req       <= '0;
      r_reqtag    <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ic_bus.ic_req) begin
            r_line_addr <= ic_bus.ic_line_addr;
            r_word      <= ic_bus.ic_word_select;
            r_state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            r_ack   <= 1'b1;
            r_data  <= {32'b0, select_word(w_rd_line, r_word)};
            r_state <= RESPOND;
          end else begin
            r_reqcyc <= 1'b1;
            r_req    <= BUS_DATA_WIDTH'({r_line_addr, 6'b0});
            r_reqtag <= BUS_TAG_WIDTH'(TAG_READ);
            r_state  <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (ic_bus.bus_reqack) begin
            r_reqcyc <= 1'b0;
            r_state  <= MISS_FILL;
          end
        end
        MISS_FILL: begin
          if (w_beat_acc) begin
            r_line_buf[r_beat] <= ic_bus.bus_resp;
            r_beat             <= r_beat + 1'b1;
            if (w_crit_beat) begin
              r_ack  <= 1'b1;
              r_data <= {32'b0, select_word(w_fill_line, r_word)};
            end
            // An early critical-word ack has already been sent, so skip RESPOND.
            if (w_last_beat) r_state <= w_crit_beat ? RESPOND : IDLE;
          end
        end
        RESPOND: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ic_bus.ic_ack      = r_ack;
  assign ic_bus.ic_data_out = r_data;
  assign ic_bus.bus_reqcyc  = r_reqcyc;
  assign ic_bus.bus_req     = r_req;
  assign ic_bus.bus_reqtag  = r_reqtag;
  assign ic_bus.bus_respack = ic_bus.bus_respcyc && (r_state != MISS_REQ);

  assign w_unused_resptag = ^ic_bus.bus_resptag;

endmodule
